// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I opcode constants, ALU function codes,
// operand-select encodings and the decoded control bundle.
package decode_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_SLL  = 3'd1,
        ALU_SLT  = 3'd2,
        ALU_SLTU = 3'd3,
        ALU_XOR  = 3'd4,
        ALU_SR   = 3'd5,
        ALU_OR   = 3'd6,
        ALU_AND  = 3'd7
    } alu_func_e;

    typedef enum logic [1:0] {
        SEL_A_RS1 = 2'd0,
        SEL_A_PC  = 2'd1,
        SEL_A_IMM = 2'd2
    } sel_a_e;

    localparam logic SEL_B_RS2 = 1'b0;
    localparam logic SEL_B_IMM = 1'b1;

    typedef struct packed {
        alu_func_e func;
        logic      control;
        sel_a_e    sel_a;
        logic      sel_b;
        logic      reg_write;
        logic      illegal;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate extraction for the supported RV32I formats (I, shift-I, U).
module imm_gen
    import decode_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [31:12] upper,
    output logic [31:0] imm
);

    logic [2:0] funct3;

    assign funct3 = upper[14:12];

    always_comb begin
        imm = '0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == 3'd1 || funct3 == 3'd5)
                    imm = {27'd0, upper[24:20]};
                else
                    imm = {{20{upper[31]}}, upper[31:20]};
            end
            OPC_LUI, OPC_AUIPC: imm = {upper[31:12], 12'd0};
            default:            imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: single-entry valid/ready output register holding the
// decoded ALU control bundle, plus a saturating illegal-instruction counter.
module decode_stage
    import decode_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [4:0]  out_rs1,
    output logic [4:0]  out_rs2,
    output logic [4:0]  out_rd,
    output logic [31:0] out_imm,
    output logic [2:0]  out_alu_func,
    output logic        out_alu_control,
    output logic [1:0]  out_sel_a,
    output logic        out_sel_b,
    output logic        out_reg_write,
    output logic        out_illegal,
    output logic [7:0]  illegal_count
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] dec_imm;
    ctrl_t       dec;
    ctrl_t       ctl_q;
    logic        valid_q;
    logic        accept;
    logic [31:0] pc_q;
    logic [31:0] imm_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    logic [7:0]  cnt_q;

    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];

    imm_gen u_imm_gen (
        .opcode (opcode),
        .upper  (in_instr[31:12]),
        .imm    (dec_imm)
    );

    always_comb begin
        dec = '{func: ALU_ADD, control: 1'b0, sel_a: SEL_A_RS1,
                sel_b: SEL_B_RS2, reg_write: 1'b0, illegal: 1'b0};
        case (opcode)
            OPC_OP_IMM: begin
                dec.func      = alu_func_e'(funct3);
                dec.sel_b     = SEL_B_IMM;
                dec.reg_write = 1'b1;
                if (funct3 == 3'd5 && funct7 == F7_ALT)
                    dec.control = 1'b1;
                else if ((funct3 == 3'd1 || funct3 == 3'd5) && funct7 != F7_BASE)
                    dec.illegal = 1'b1;
            end
            OPC_OP: begin
                dec.func      = alu_func_e'(funct3);
                dec.reg_write = 1'b1;
                if (funct7 == F7_ALT) begin
                    if (funct3 == 3'd5) dec.control = 1'b1;
                    else                dec.illegal = 1'b1;
                end else if (funct7 != F7_BASE) begin
                    dec.illegal = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.sel_a     = SEL_A_IMM;
                dec.sel_b     = SEL_B_IMM;
                dec.control   = 1'b1;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.sel_a     = SEL_A_PC;
                dec.sel_b     = SEL_B_IMM;
                dec.reg_write = 1'b1;
            end
            default: dec.illegal = 1'b1;
        endcase
        // Illegal bundles still travel downstream but must have no side effects.
        if (dec.illegal) begin
            dec.func      = ALU_ADD;
            dec.control   = 1'b0;
            dec.reg_write = 1'b0;
        end
        if (in_instr[11:7] == 5'd0)
            dec.reg_write = 1'b0;
    end

    assign in_ready = (!valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            imm_q   <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
            ctl_q   <= '0;
            cnt_q   <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (accept) begin
                valid_q <= 1'b1;
                pc_q    <= in_pc;
                imm_q   <= dec_imm;
                rs1_q   <= in_instr[19:15];
                rs2_q   <= in_instr[24:20];
                rd_q    <= in_instr[11:7];
                ctl_q   <= dec;
            end else if (out_ready) begin
                valid_q <= 1'b0;
            end
            // A flushed bundle is discarded, so its handshake does not count.
            if (valid_q && out_ready && ctl_q.illegal && !flush && cnt_q != 8'hFF)
                cnt_q <= cnt_q + 8'd1;
        end
    end

    assign out_valid       = valid_q;
    assign out_pc          = pc_q;
    assign out_rs1         = rs1_q;
    assign out_rs2         = rs2_q;
    assign out_rd          = rd_q;
    assign out_imm         = imm_q;
    assign out_alu_func    = ctl_q.func;
    assign out_alu_control = ctl_q.control;
    assign out_sel_a       = ctl_q.sel_a;
    assign out_sel_b       = ctl_q.sel_b;
    assign out_reg_write   = ctl_q.reg_write;
    assign out_illegal     = ctl_q.illegal;
    assign illegal_count   = cnt_q;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the stage.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, out_pc, out_imm;
    logic [4:0]  out_rs1, out_rs2, out_rd;
    logic [2:0]  out_alu_func;
    logic        out_alu_control, out_sel_b, out_reg_write, out_illegal;
    logic [1:0]  out_sel_a;
    logic [7:0]  illegal_count;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_alu_func(out_alu_func), .out_alu_control(out_alu_control),
        .out_sel_a(out_sel_a), .out_sel_b(out_sel_b), .out_reg_write(out_reg_write),
        .out_illegal(out_illegal), .illegal_count(illegal_count)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [2:0]  func;
        logic        ctrl;
        logic [1:0]  sel_a;
        logic        sel_b, rw, ill;
        logic [6:0]  op;
    } exp_t;

    exp_t        m;
    logic        m_valid;
    int unsigned m_cnt;

    function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] pc);
        exp_t e;
        logic [6:0] op = ins[6:0];
        logic [2:0] f3 = ins[14:12];
        logic [6:0] f7 = ins[31:25];
        bit shift, alt;
        shift = (op == 7'h13) && (f3 == 3'd1 || f3 == 3'd5);
        alt   = (f3 == 3'd5) && (f7 == 7'h20);
        e.pc = pc; e.op = op;
        e.rs1 = ins[19:15]; e.rs2 = ins[24:20]; e.rd = ins[11:7];
        e.ill = !((op == 7'h13 && (!shift || f7 == 7'h00 || alt)) ||
                  (op == 7'h33 && (f7 == 7'h00 || alt)) ||
                  op == 7'h37 || op == 7'h17);
        if (op == 7'h37 || op == 7'h17) e.imm = {ins[31:12], 12'h000};
        else if (shift)                 e.imm = 32'(ins[24:20]);
        else if (op == 7'h13)           e.imm = 32'($signed(ins[31:20]));
        else                            e.imm = 32'h0;
        e.sel_a = (op == 7'h37) ? 2'd2 : (op == 7'h17) ? 2'd1 : 2'd0;
        e.sel_b = (op != 7'h33);
        e.func  = (!e.ill && (op == 7'h13 || op == 7'h33)) ? f3 : 3'd0;
        e.ctrl  = !e.ill && (op == 7'h37 || ((op == 7'h13 || op == 7'h33) && alt));
        e.rw    = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic logic [6:0] pick_f7();
        case ($urandom_range(0, 2))
            0:       return 7'h00;
            1:       return 7'h20;
            default: return 7'($urandom);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        case ($urandom_range(0, 7))
            0, 1: w[6:0] = 7'h13;
            2: begin
                w[6:0] = 7'h13;
                w[14:12] = ($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5;
                w[31:25] = pick_f7();
            end
            3, 4: begin w[6:0] = 7'h33; w[31:25] = pick_f7(); end
            5: w[6:0] = 7'h37;
            6: w[6:0] = 7'h17;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_all();
        check("in_ready", in_ready, (!m_valid || out_ready) && !flush);
        check("out_valid", out_valid, m_valid);
        check("illegal_count", illegal_count, m_cnt);
        if (m_valid) begin
            check("pc", out_pc, m.pc);
            check("rs1", out_rs1, m.rs1);
            check("rd", out_rd, m.rd);
            check("illegal", out_illegal, m.ill);
            check("reg_write", out_reg_write, m.rw);
            check("func", out_alu_func, m.func);
            check("control", out_alu_control, m.ctrl);
            if (!m.ill) begin
                check("sel_a", out_sel_a, m.sel_a);
                if (m.op != 7'h37) check("sel_b", out_sel_b, m.sel_b);
                if (m.op != 7'h33) check("imm", out_imm, m.imm);
                if (m.op == 7'h33) check("rs2", out_rs2, m.rs2);
            end
        end
    endtask

    // Drive one cycle's inputs, check outputs mid-cycle, advance the model.
    task automatic tick(input logic r, input logic v, input logic [31:0] ins,
                        input logic [31:0] p, input logic fl, input logic rdy);
        rst = r; in_valid = v; in_instr = ins; in_pc = p; flush = fl; out_ready = rdy;
        @(negedge clk);
        check_all();
        if (r) begin
            m_valid = 1'b0; m_cnt = 0; m = '{default: '0};
        end else if (fl) begin
            m_valid = 1'b0;
        end else begin
            if (m_valid && rdy && m.ill && m_cnt != 255) m_cnt++;
            if (v && (!m_valid || rdy)) begin
                m = model_decode(ins, p);
                m_valid = 1'b1;
            end else if (rdy) begin
                m_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        m_valid = 1'b0; m_cnt = 0; m = '{default: '0};
        @(posedge clk); #1;
        tick(1, 0, 0, 0, 0, 0);
        check("rst_valid", out_valid, 0);
        check("rst_count", illegal_count, 0);
        check("rst_pc", out_pc, 0);
        check("rst_imm", out_imm, 0);
        check("rst_fields", {out_rs1, out_rs2, out_rd, out_alu_func, out_alu_control,
                             out_sel_a, out_sel_b, out_reg_write, out_illegal}, 0);
        rst = 1'b0;
        #1 check("in_ready_after_rst", in_ready, 1);

        tick(0, 1, 32'h00510093, 32'h100, 0, 1);
        check("addi_func", out_alu_func, 0);
        check("addi_ctrl", out_alu_control, 0);
        check("addi_sel_a", out_sel_a, 0);
        check("addi_sel_b", out_sel_b, 1);
        check("addi_imm", out_imm, 5);
        check("addi_rs1", out_rs1, 2);
        check("addi_rd", out_rd, 1);
        check("addi_rw", out_reg_write, 1);

        tick(0, 1, 32'h123452B7, 32'h104, 0, 1);
        check("lui_imm", out_imm, 32'h12345000);
        check("lui_sel_a", out_sel_a, 2);
        check("lui_func", out_alu_func, 0);
        check("lui_ctrl", out_alu_control, 1);
        check("lui_rd", out_rd, 5);

        tick(0, 1, 32'h40325193, 32'h108, 0, 1);
        check("srai_func", out_alu_func, 5);
        check("srai_ctrl", out_alu_control, 1);
        check("srai_imm", out_imm, 3);
        check("srai_ill", out_illegal, 0);

        tick(0, 1, 32'h403100B3, 32'h10C, 0, 1);
        check("sub_ill", out_illegal, 1);
        check("sub_rw", out_reg_write, 0);
        check("sub_cnt_before", illegal_count, 0);
        tick(0, 0, 0, 0, 0, 1);
        check("sub_cnt_after", illegal_count, 1);

        tick(0, 1, 32'h00510093, 32'h200, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 1, 32'h123452B7, 32'h204, 0, 0);
            check("stall_in_ready", in_ready, 0);
            check("stall_pc", out_pc, 32'h200);
            check("stall_imm", out_imm, 5);
        end
        tick(0, 1, 32'h123452B7, 32'h204, 0, 1);
        check("stall_second_pc", out_pc, 32'h204);
        check("stall_second_imm", out_imm, 32'h12345000);
        tick(0, 0, 0, 0, 0, 1);
        check("stall_drain", out_valid, 0);

        tick(0, 1, 32'hFFFFFFFF, 32'h300, 1, 1);
        check("flush_valid", out_valid, 0);
        check("flush_cnt", illegal_count, 1);
        tick(0, 1, 32'h403100B3, 32'h304, 0, 0);
        tick(0, 0, 0, 0, 1, 1);
        check("flush_held_valid", out_valid, 0);
        check("flush_held_cnt", illegal_count, 1);

        tick(0, 1, 32'h00510093, 32'h400, 0, 0);
        tick(1, 1, 32'h00510093, 32'h404, 1, 1);
        check("rst_override_valid", out_valid, 0);
        check("rst_override_cnt", illegal_count, 0);

        for (int i = 0; i < 3000; i++)
            tick(($urandom_range(0, 999) == 0), ($urandom_range(0, 3) != 0), rand_instr(),
                 $urandom, ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));

        tick(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 600; i++)
            tick(0, 1, 32'h0000007F, 32'(i * 4), 0, 1);
        check("saturate", illegal_count, 255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
